bsg_mem_1r1w_sync_reader: RTL and testbench

Read-side initiator for a `bsg_mem_1r1w_sync` instance. It accepts a burst command (start address, word count), issues sequential synchronous reads on the memory read port, and absorbs the one-cycle read latency. Data is returned on a valid/yumi stream with a per-word last flag. It sits between a synchronous-read RAM and any consumer that can apply backpressure, for example a SHA-256 message-block fetch.

---
 rtl/bsg_mem_1r1w_sync_reader.sv | 146 ++++++++++++++
 tb/tb_bsg_mem_1r1w_sync_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1r1w_sync_reader.sv
// bsg_mem_1r1w_sync_reader: burst read initiator for a synchronous-read 1R1W memory.
// Issues sequential reads, absorbs the one-cycle read latency into a 2-entry output
// buffer, and presents words on a valid/yumi stream with a per-word last flag.
// Optional feature macro: BSG_MEM_1R1W_SYNC_READER_WRAP_EN (explicit wrap at els_p-1).
module bsg_mem_1r1w_sync_reader #(
  parameter int width_p       = -1,
  parameter int els_p         = -1,
  parameter int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic [addr_width_lp-1:0] cmd_addr_i,
  input  logic [addr_width_lp-1:0] cmd_len_i,

  output logic                     mem_r_v_o,
  output logic [addr_width_lp-1:0] mem_r_addr_o,
  input  logic [width_p-1:0]       mem_r_data_i,

  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic                     last_o,
  input  logic                     yumi_i
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                   state_r;
  logic [addr_width_lp-1:0] addr_r;
  logic [addr_width_lp-1:0] hold_addr_r;
  logic [addr_width_lp:0]   remaining_r;
  logic                     inflight_r;
  logic                     inflight_last_r;

  logic [1:0]               occ_r;
  logic                     head_r;
  logic [width_p-1:0]       buf_data_r [2];
  logic                     buf_last_r [2];

  logic                     accept;
  logic                     issue;
  logic                     last_issue;
  logic                     deq;
  logic                     enq;
  logic                     tail;
  logic [2:0]               credit;
  logic [addr_width_lp-1:0] addr_next;

  // Handshakes, issue credit and output muxing
  always_comb begin
    v_o          = (occ_r != 2'd0);
    data_o       = buf_data_r[head_r];
    last_o       = buf_last_r[head_r];
    deq          = yumi_i & v_o;
    enq          = inflight_r;
    tail         = head_r ^ occ_r[0];
    // Slots that will be committed after this edge; deq only when occ_r >= 1, so no underflow.
    credit       = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, deq};
    cmd_ready_o  = ~reset_i & (state_r == StIdle);
    accept       = cmd_v_i & cmd_ready_o;
    issue        = ~reset_i & (state_r == StBusy) & (credit < 3'd2);
    last_issue   = (remaining_r == {{addr_width_lp{1'b0}}, 1'b1});
    mem_r_v_o    = issue;
    mem_r_addr_o = issue ? addr_r : hold_addr_r;
  end

  // Next sequential read address
`ifdef BSG_MEM_1R1W_SYNC_READER_WRAP_EN
  localparam logic [addr_width_lp-1:0] LastAddr = addr_width_lp'(els_p - 1);

  always_comb begin
    addr_next = (addr_r == LastAddr) ? '0 : addr_r + addr_width_lp'(1);
  end
`else
  always_comb begin
    addr_next = addr_r + addr_width_lp'(1);
  end
`endif

  // Command FSM, address/count tracking and in-flight read bookkeeping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r         <= StIdle;
      addr_r          <= '0;
      hold_addr_r     <= '0;
      remaining_r     <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      inflight_r <= issue;
      if (issue) begin
        hold_addr_r     <= addr_r;
        addr_r          <= addr_next;
        remaining_r     <= remaining_r - {{addr_width_lp{1'b0}}, 1'b1};
        inflight_last_r <= last_issue;
      end
      unique case (state_r)
        StIdle: begin
          if (accept) begin
            state_r     <= StBusy;
            addr_r      <= cmd_addr_i;
            remaining_r <= {1'b0, cmd_len_i} + {{addr_width_lp{1'b0}}, 1'b1};
          end
        end
        StBusy: begin
          if (issue && last_issue) state_r <= StIdle;
        end
        default: state_r <= StIdle;
      endcase
    end
  end

  // Two-entry output buffer; issue credit guarantees enq never meets a full buffer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_r  <= 2'd0;
      head_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_r[i] <= '0;
        buf_last_r[i] <= 1'b0;
      end
    end else begin
      if (enq) begin
        buf_data_r[tail] <= mem_r_data_i;
        buf_last_r[tail] <= inflight_last_r;
      end
      if (deq) head_r <= ~head_r;
      occ_r <= occ_r + {1'b0, enq} - {1'b0, deq};
    end
  end

`ifndef BSG_MEM_1R1W_SYNC_READER_WRAP_EN
`ifndef SYNTHESIS
  // Without explicit wrap, reads past the end of a non-power-of-two memory are illegal
  always_ff @(posedge clk_i) begin
    if (!reset_i && mem_r_v_o) begin
      assert (int'(mem_r_addr_o) < els_p)
        else $error("read address %0d beyond els_p=%0d", mem_r_addr_o, els_p);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_reader.sv
// Directed self-checking bench for bsg_mem_1r1w_sync_reader (els_p=12, width_p=16).
module tb_bsg_mem_1r1w_sync_reader;

  localparam int W = 16;
  localparam int E = 12;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         cmd_v_i = 1'b0;
  logic         cmd_ready_o;
  logic [A-1:0] cmd_addr_i = '0;
  logic [A-1:0] cmd_len_i = '0;
  logic         mem_r_v_o;
  logic [A-1:0] mem_r_addr_o;
  logic [W-1:0] mem_r_data_i = '0;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         last_o;
  logic         yumi_i = 1'b0;

  int total = 0;
  int bad = 0;

  logic [W-1:0] mem [E];

  bsg_mem_1r1w_sync_reader #(
    .width_p(W),
    .els_p  (E)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cmd_v_i     (cmd_v_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .mem_r_v_o   (mem_r_v_o),
    .mem_r_addr_o(mem_r_addr_o),
    .mem_r_data_i(mem_r_data_i),
    .v_o         (v_o),
    .data_o      (data_o),
    .last_o      (last_o),
    .yumi_i      (yumi_i)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model: mem[k] = 0x100 + k
  initial for (int k = 0; k < E; k++) mem[k] = W'(16'h100 + k);
  always @(posedge clk) begin
    if (mem_r_v_o && int'(mem_r_addr_o) < E) mem_r_data_i <= mem[mem_r_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_addr(input int a, input int k);
`ifdef BSG_MEM_1R1W_SYNC_READER_WRAP_EN
    return (a + k) % E;
`else
    return a + k;
`endif
  endfunction

  // One burst with yumi held high; checks issued addresses, data order, last flags, counts
  task automatic burst_check(input string tag, input int a, input int l);
    int iss;
    int widx;
    iss = 0;
    widx = 0;
    cmd_v_i = 1'b1;
    cmd_addr_i = A'(a);
    cmd_len_i = A'(l);
    yumi_i = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
    for (int c = 0; c < 40; c++) begin
      step();
      if (c == 0) cmd_v_i = 1'b0;
      #1;
      if (mem_r_v_o) begin
        check({tag, "_raddr"}, 32'(mem_r_addr_o), 32'(exp_addr(a, iss)));
        iss++;
      end
      if (v_o) begin
        check({tag, "_data"}, 32'(data_o), 32'(16'h100 + exp_addr(a, widx)));
        check({tag, "_last"}, 32'(last_o), 32'(widx == l));
        widx++;
      end
    end
    check({tag, "_nreads"}, 32'(iss), 32'(l + 1));
    check({tag, "_nwords"}, 32'(widx), 32'(l + 1));
  endtask

  initial begin
    int nrd;
    int widx;
    int nacc;
    logic [W-1:0] seq_data [4];
    logic         seq_last [4];

    // ---- reset ----
    step();
    #1;
    check("rst_ready", 32'(cmd_ready_o), 32'd0);
    check("rst_memv", 32'(mem_r_v_o), 32'd0);
    step();
    step();
    reset_i = 1'b0;
    // ---- test 1: single word at addr 5 ----
    cmd_v_i = 1'b1;
    cmd_addr_i = 4'd5;
    cmd_len_i = 4'd0;
    yumi_i = 1'b1;
    #1;
    check("t0_ready", 32'(cmd_ready_o), 32'd1);
    check("t0_v", 32'(v_o), 32'd0);
    check("t0_data", 32'(data_o), 32'd0);
    check("t0_last", 32'(last_o), 32'd0);
    check("t0_memv", 32'(mem_r_v_o), 32'd0);
    check("t0_raddr", 32'(mem_r_addr_o), 32'd0);
    step();
    cmd_v_i = 1'b0;
    #1;
    check("t1_memv", 32'(mem_r_v_o), 32'd1);
    check("t1_raddr", 32'(mem_r_addr_o), 32'd5);
    check("t1_ready", 32'(cmd_ready_o), 32'd0);
    step();
    #1;
    check("t2_memv", 32'(mem_r_v_o), 32'd0);
    check("t2_raddr_hold", 32'(mem_r_addr_o), 32'd5);
    check("t2_ready", 32'(cmd_ready_o), 32'd1);
    check("t2_v", 32'(v_o), 32'd0);
    step();
    #1;
    check("t3_v", 32'(v_o), 32'd1);
    check("t3_data", 32'(data_o), 32'h105);
    check("t3_last", 32'(last_o), 32'd1);
    step();
    #1;
    check("t4_v", 32'(v_o), 32'd0);

    // ---- test 2: 8-word burst, no stalls, cycle-exact timing ----
    cmd_v_i = 1'b1;
    cmd_addr_i = 4'd0;
    cmd_len_i = 4'd7;
    yumi_i = 1'b1;
    #1;
    check("b8_ready0", 32'(cmd_ready_o), 32'd1);
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 1) cmd_v_i = 1'b0;
      #1;
      check("b8_memv", 32'(mem_r_v_o), 32'(c >= 1 && c <= 8));
      if (c <= 8) check("b8_raddr", 32'(mem_r_addr_o), 32'(c - 1));
      check("b8_ready", 32'(cmd_ready_o), 32'(c >= 9));
      check("b8_v", 32'(v_o), 32'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) begin
        check("b8_data", 32'(data_o), 32'(16'h100 + c - 3));
        check("b8_last", 32'(last_o), 32'(c == 10));
      end
    end

    // ---- test 3: backpressure for 10 cycles ----
    cmd_v_i = 1'b1;
    cmd_addr_i = 4'd0;
    cmd_len_i = 4'd7;
    yumi_i = 1'b0;
    nrd = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) cmd_v_i = 1'b0;
      #1;
      if (mem_r_v_o) nrd++;
    end
    check("bp_nreads", 32'(nrd), 32'd2);
    check("bp_v", 32'(v_o), 32'd1);
    check("bp_data", 32'(data_o), 32'h100);
    yumi_i = 1'b1;
    #1;
    check("bp_resume_memv", 32'(mem_r_v_o), 32'd1);
    check("bp_resume_raddr", 32'(mem_r_addr_o), 32'd2);
    widx = 0;
    for (int i = 0; i < 20 && widx < 8; i++) begin
      if (v_o) begin
        check("bp_data", 32'(data_o), 32'(16'h100 + widx));
        check("bp_last", 32'(last_o), 32'(widx == 7));
        widx++;
      end
      if (widx < 8) begin
        step();
        #1;
      end
    end
    check("bp_nwords", 32'(widx), 32'd8);
    step();
    #1;
    check("bp_end_v", 32'(v_o), 32'd0);
    check("bp_end_ready", 32'(cmd_ready_o), 32'd1);

    // ---- test 4: back-to-back commands ----
    seq_data[0] = 16'h102; seq_last[0] = 1'b0;
    seq_data[1] = 16'h103; seq_last[1] = 1'b1;
    seq_data[2] = 16'h109; seq_last[2] = 1'b0;
    seq_data[3] = 16'h10A; seq_last[3] = 1'b1;
    widx = 0;
    nacc = 0;
    cmd_v_i = 1'b1;
    cmd_addr_i = 4'd2;
    cmd_len_i = 4'd1;
    yumi_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (v_o) begin
        if (widx < 4) begin
          check("b2b_data", 32'(data_o), 32'(seq_data[widx]));
          check("b2b_last", 32'(last_o), 32'(seq_last[widx]));
        end
        widx++;
      end
      if (cmd_v_i && cmd_ready_o) nacc++;
      step();
      cmd_addr_i = 4'd9;
      cmd_v_i = (nacc < 2);
    end
    check("b2b_nwords", 32'(widx), 32'd4);
    check("b2b_naccept", 32'(nacc), 32'd2);

    // ---- test 5: end-of-memory addressing ----
`ifdef BSG_MEM_1R1W_SYNC_READER_WRAP_EN
    burst_check("wrap", 10, 3);
`else
    burst_check("top", 10, 1);
`endif

    // ---- test 6: reset mid-burst with words buffered ----
    cmd_v_i = 1'b1;
    cmd_addr_i = 4'd0;
    cmd_len_i = 4'd7;
    yumi_i = 1'b0;
    step();
    cmd_v_i = 1'b0;
    step();
    step();
    step();
    #1;
    check("mr_pre_v", 32'(v_o), 32'd1);
    reset_i = 1'b1;
    #1;
    check("mr_rst_memv", 32'(mem_r_v_o), 32'd0);
    check("mr_rst_ready", 32'(cmd_ready_o), 32'd0);
    step();
    reset_i = 1'b0;
    #1;
    check("mr_post_v", 32'(v_o), 32'd0);
    check("mr_post_memv", 32'(mem_r_v_o), 32'd0);
    check("mr_post_ready", 32'(cmd_ready_o), 32'd1);
    check("mr_post_data", 32'(data_o), 32'd0);
    burst_check("post_rst", 3, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
